ifetch_buffered: RTL and testbench

Parametrised, decoupled instruction fetch unit. It issues line-wide reads to the instruction cache, one per accepted response. Returned lines go into a small instruction queue together with a per-slot valid mask and the line base PC. Decode drains the queue through a valid/ready handshake, so fetch keeps running while decode stalls. A redirect (`load_pc`) flushes the queue and any same-cycle response.

---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/ifetch_buffered.sv | 93 +++++++++
 tb/tb_ifetch_buffered.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the buffered instruction fetch unit.
package ifetch_pkg;

   localparam int ADDR_W     = 32;
   localparam int FETCH_W    = 4;
   localparam int WORD_IDX_W = $clog2(FETCH_W);
   localparam int LINE_BYTES = 4 * FETCH_W;
   localparam int MASK_MAX   = 64;

   typedef struct packed {
      logic [32*FETCH_W-1:0] words;
      logic [FETCH_W-1:0]    mask;
      logic [ADDR_W-1:0]     pc;
   } fetch_entry_t;

   // Slots at or after the entry offset are valid; callers truncate to their line width.
   function automatic logic [MASK_MAX-1:0] line_mask(input int unsigned idx);
      logic [MASK_MAX-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_MAX; i++) begin
         m[i] = (i >= idx);
      end
      return m;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous line queue between fetch and decode; flush wins over push/pop.
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 4,
   localparam int PW      = $clog2(DEPTH)
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   push,
   input  logic   pop,
   input  logic   flush,
   input  entry_t wdata,
   output logic   full,
   output logic   empty,
   output logic [PW:0] count,
   output entry_t head
);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_comb begin
      do_push = push & ~full & ~flush & reset_n;
      do_pop  = pop & ~empty & ~flush & reset_n;
   end

   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is only observed while count is nonzero.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ifetch_buffered.sv
// Decoupled line fetch: PC register, cache request/accept, slot mask, gated queue head.
module ifetch_buffered
   import ifetch_pkg::*;
#(
   parameter int                  ADDR_WIDTH  = 32,
   parameter int                  FETCH_WORDS = 4,
   parameter int                  QDEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic [ADDR_WIDTH-1:0]     cache_addr,
   output logic                      cache_rd,
   input  logic [32*FETCH_WORDS-1:0] cache_data,
   input  logic                      cache_waitrequest,
   input  logic                      load_pc,
   input  logic [ADDR_WIDTH-1:0]     new_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [32*FETCH_WORDS-1:0] out_words,
   output logic [FETCH_WORDS-1:0]    out_mask,
   output logic [ADDR_WIDTH-1:0]     out_pc,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic                      branch_stall
);

   localparam int WI     = $clog2(FETCH_WORDS);
   localparam int LINE_B = 4 * FETCH_WORDS;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_B - 1);

   typedef struct packed {
      logic [32*FETCH_WORDS-1:0] words;
      logic [FETCH_WORDS-1:0]    mask;
      logic [ADDR_WIDTH-1:0]     pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0]  pc;
   logic [ADDR_WIDTH-1:0]  base;
   logic [WI-1:0]          line_idx;
   logic [FETCH_WORDS-1:0] new_mask;
   logic                   accept;
   logic                   pop;
   logic                   full;
   logic                   empty;
   entry_t                 wdata;
   entry_t                 head;

   assign line_idx = pc[WI+1:2];
   assign base     = pc & ~OFF_MASK;
   assign new_mask = FETCH_WORDS'(line_mask(32'(line_idx)));

   assign cache_addr   = pc;
   assign cache_rd     = ~full & ~load_pc;
   assign accept       = cache_rd & ~cache_waitrequest;
   assign branch_stall = cache_rd & cache_waitrequest;

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   assign wdata = '{words: cache_data, mask: new_mask, pc: base};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else if (load_pc) begin
         pc <= new_pc & ~ADDR_WIDTH'(3);
      end else if (accept) begin
         pc <= base + ADDR_WIDTH'(LINE_B);
      end
   end

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (QDEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (accept),
      .pop     (pop),
      .flush   (load_pc),
      .wdata   (wdata),
      .full    (full),
      .empty   (empty),
      .count   (q_count),
      .head    (head)
   );

   // Head is gated so an empty queue presents all-zero payload.
   assign out_words = empty ? '0 : head.words;
   assign out_mask  = empty ? '0 : head.mask;
   assign out_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_ifetch_buffered.sv
// Directed bench for ifetch_buffered with a simple address-derived cache model.
module tb_ifetch_buffered;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [31:0]  cache_addr;
   logic         cache_rd;
   logic [127:0] cache_data;
   logic         cache_waitrequest;
   logic         load_pc;
   logic [31:0]  new_pc;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_words;
   logic [3:0]   out_mask;
   logic [31:0]  out_pc;
   logic [2:0]   q_count;
   logic         branch_stall;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   ifetch_buffered #(
      .ADDR_WIDTH  (32),
      .FETCH_WORDS (4),
      .QDEPTH      (4),
      .RESET_PC    (32'h0)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .cache_addr        (cache_addr),
      .cache_rd          (cache_rd),
      .cache_data        (cache_data),
      .cache_waitrequest (cache_waitrequest),
      .load_pc           (load_pc),
      .new_pc            (new_pc),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_words         (out_words),
      .out_mask          (out_mask),
      .out_pc            (out_pc),
      .q_count           (q_count),
      .branch_stall      (branch_stall)
   );

   // Cache returns word k of a line as its own byte address; slot 0 in MS bits.
   function automatic logic [127:0] line_words(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'hF;
      return {b, b + 32'd4, b + 32'd8, b + 32'd12};
   endfunction

   assign cache_data = line_words(cache_addr);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; cache_waitrequest = 1'b0; load_pc = 1'b0;
      new_pc = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_q_count", 128'(q_count), 0);
      check("rst_out_valid", 128'(out_valid), 0);
      check("rst_out_words", out_words, 0);
      check("rst_out_mask", 128'(out_mask), 0);
      check("rst_out_pc", 128'(out_pc), 0);
      check("rst_cache_rd", 128'(cache_rd), 1);
      check("rst_cache_addr", 128'(cache_addr), 0);

      // Streaming
      reset_n = 1'b1; out_ready = 1'b1;
      tick();
      check("s1_addr", 128'(cache_addr), 128'h10);
      check("s1_valid", 128'(out_valid), 1);
      check("s1_pc", 128'(out_pc), 0);
      check("s1_mask", 128'(out_mask), 128'hF);
      check("s1_words", out_words, line_words(32'h0));
      check("s1_count", 128'(q_count), 1);
      tick();
      check("s2_addr", 128'(cache_addr), 128'h20);
      check("s2_pc", 128'(out_pc), 128'h10);
      check("s2_count", 128'(q_count), 1);
      tick();
      check("s3_addr", 128'(cache_addr), 128'h30);
      check("s3_pc", 128'(out_pc), 128'h20);
      check("s3_count", 128'(q_count), 1);

      // Unaligned redirect
      load_pc = 1'b1; new_pc = 32'h107;
      #1;
      check("rd_cache_rd_low", 128'(cache_rd), 0);
      tick();
      load_pc = 1'b0;
      check("rd_addr", 128'(cache_addr), 128'h104);
      check("rd_valid", 128'(out_valid), 0);
      check("rd_count", 128'(q_count), 0);
      check("rd_words_gated", out_words, 0);
      tick();
      check("rd_entry_pc", 128'(out_pc), 128'h100);
      check("rd_entry_mask", 128'(out_mask), 128'hE);
      check("rd_entry_words", out_words, line_words(32'h100));
      check("rd_next_addr", 128'(cache_addr), 128'h110);

      // Backpressure from a fresh reset
      reset_n = 1'b0; out_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      tick(); tick(); tick();
      check("bp_count3", 128'(q_count), 3);
      tick();
      check("bp_count4", 128'(q_count), 4);
      check("bp_rd_low", 128'(cache_rd), 0);
      check("bp_addr", 128'(cache_addr), 128'h40);
      tick();
      check("bp_addr_hold", 128'(cache_addr), 128'h40);
      check("bp_head_pc", 128'(out_pc), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_pop_count", 128'(q_count), 3);
      check("bp_rd_back", 128'(cache_rd), 1);
      check("bp_pop_head", 128'(out_pc), 128'h10);
      tick();
      check("bp_refill_count", 128'(q_count), 4);
      check("bp_refill_addr", 128'(cache_addr), 128'h50);

      // Cache wait
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; cache_waitrequest = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("cw_stall", 128'(branch_stall), 1);
         check("cw_addr", 128'(cache_addr), 128'h50);
         check("cw_count", 128'(q_count), 3);
         tick();
      end
      cache_waitrequest = 1'b0;
      #1;
      check("cw_stall_off", 128'(branch_stall), 0);
      tick();
      check("cw_resume_count", 128'(q_count), 4);
      check("cw_resume_addr", 128'(cache_addr), 128'h60);

      // Flush with simultaneous accept-ready and pop
      out_ready = 1'b1;
      tick();
      check("fl_pre_count", 128'(q_count), 3);
      load_pc = 1'b1; new_pc = 32'h200;
      tick();
      load_pc = 1'b0;
      check("fl_count", 128'(q_count), 0);
      check("fl_valid", 128'(out_valid), 0);
      check("fl_addr", 128'(cache_addr), 128'h200);
      tick();
      check("fl_first_pc", 128'(out_pc), 128'h200);
      check("fl_first_mask", 128'(out_mask), 128'hF);
      check("fl_first_count", 128'(q_count), 1);

      // Mid-stream reset while full
      out_ready = 1'b0;
      tick(); tick(); tick();
      check("mr_full", 128'(q_count), 4);
      reset_n = 1'b0;
      tick();
      check("mr_count", 128'(q_count), 0);
      check("mr_valid", 128'(out_valid), 0);
      check("mr_addr", 128'(cache_addr), 0);
      check("mr_words", out_words, 0);
      check("mr_mask", 128'(out_mask), 0);
      check("mr_pc", 128'(out_pc), 0);
      check("mr_rd", 128'(cache_rd), 1);
      reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
